// File: rtl/run_len_meter_if.sv
// Handshake/status bundle between the run detector, run_len_meter and the
// downstream result consumer.
interface run_len_meter_if #(
  parameter int CNT_W = 8,
  parameter int NB_W  = 16
);
  logic             r;
  logic             f;
  logic             ready_i;
  logic             valid_o;
  logic [CNT_W-1:0] len_o;
  logic             sat_o;
  logic             drop_o;
  logic             err_o;
  logic [NB_W-1:0]  nruns_o;

  modport master (
    output r, f, ready_i,
    input  valid_o, len_o, sat_o, drop_o, err_o, nruns_o
  );

  modport slave (
    input  r, f, ready_i,
    output valid_o, len_o, sat_o, drop_o, err_o, nruns_o
  );
endinterface

// File: rtl/run_len_meter.sv
// Measures the length of each r-high run and offers it downstream through a
// single-entry valid/ready result register with drop and protocol-error pulses.
module run_len_meter #(
  parameter int CNT_W = 8,
  parameter int NB_W  = 16
) (
  input logic           clk,
  input logic           rst_n,
  run_len_meter_if.slave bus
);

  typedef enum logic {IDLE, COUNT} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             satf_q, satf_d;
  logic             cap;
  logic             err_q, err_d;

  logic             valid_q, valid_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             sat_q, sat_d;
  logic             drop_q, drop_d;
  logic [NB_W-1:0]  nruns_q, nruns_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      satf_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      satf_q  <= satf_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    satf_d  = satf_q;
    cap     = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        satf_d = 1'b0;
        if (bus.f) begin
          err_d = 1'b1;
        end else if (bus.r) begin
          state_d = COUNT;
          cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
          satf_d  = (cnt_d == '1);
        end
      end
      COUNT: begin
        if (bus.f) begin
          // f wins over r; a coincident r is flagged but not counted
          cap     = 1'b1;
          err_d   = bus.r;
          state_d = IDLE;
          cnt_d   = '0;
          satf_d  = 1'b0;
        end else if (bus.r) begin
          cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
          satf_d = satf_q | (cnt_d == '1);
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
          satf_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      len_q   <= '0;
      sat_q   <= 1'b0;
      drop_q  <= 1'b0;
      nruns_q <= '0;
    end else begin
      valid_q <= valid_d;
      len_q   <= len_d;
      sat_q   <= sat_d;
      drop_q  <= drop_d;
      nruns_q <= nruns_d;
    end
  end

  // The result slot frees in the same cycle it is consumed, so a capture
  // coinciding with a transfer overwrites instead of dropping.
  always_comb begin
    valid_d = valid_q;
    len_d   = len_q;
    sat_d   = sat_q;
    nruns_d = nruns_q;
    drop_d  = 1'b0;
    if (cap && (!valid_q || bus.ready_i)) begin
      valid_d = 1'b1;
      len_d   = cnt_q;
      sat_d   = satf_q;
      nruns_d = (nruns_q == '1) ? nruns_q : nruns_q + 1'b1;
    end else if (cap) begin
      drop_d = 1'b1;
    end else if (valid_q && bus.ready_i) begin
      valid_d = 1'b0;
    end
  end

  assign bus.valid_o = valid_q;
  assign bus.len_o   = len_q;
  assign bus.sat_o   = sat_q;
  assign bus.drop_o  = drop_q;
  assign bus.err_o   = err_q;
  assign bus.nruns_o = nruns_q;

endmodule

// File: tb/tb_run_len_meter.sv
// Randomized + directed bench for run_len_meter: a run-level reference model
// queues expected results/pulses, a monitor pops and compares them.
module tb_run_len_meter;
  localparam int CNT_W = 8;
  localparam int NB_W  = 16;
  localparam int MAXL  = (1 << CNT_W) - 1;
  localparam int MAXN  = (1 << NB_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic r_s = 1'b0, f_s = 1'b0, rdy_s = 1'b0;
  int   rdy_mode = 0;

  int total = 0;
  int bad   = 0;

  run_len_meter_if #(.CNT_W(CNT_W), .NB_W(NB_W)) bus ();
  assign bus.r       = r_s;
  assign bus.f       = f_s;
  assign bus.ready_i = rdy_s;

  run_len_meter #(.CNT_W(CNT_W), .NB_W(NB_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // reference model state
  int      cyc = 0;
  bit      in_run = 0;
  int      run_len = 0;
  bit      has = 0;
  int      nruns = 0;
  int      exp_q[$];
  int      err_q[$];
  int      drop_q[$];

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Model: a run is a count of consecutive r samples ended by f.
  initial forever begin
    bit cap, err;
    int res;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      in_run = 0; run_len = 0; has = 0; nruns = 0;
      exp_q.delete(); err_q.delete(); drop_q.delete();
    end else begin
      cap = 0; err = 0; res = 0;
      if (f_s) begin
        if (in_run) begin
          cap = 1;
          res = ((run_len >= MAXL) ? MAXL : run_len) | ((run_len >= MAXL) ? (1 << CNT_W) : 0);
          err = r_s;
        end else err = 1;
        in_run = 0; run_len = 0;
      end else if (r_s) begin
        if (!in_run) begin in_run = 1; run_len = 1; end
        else run_len++;
      end else begin
        if (in_run) err = 1;
        in_run = 0; run_len = 0;
      end
      if (err) err_q.push_back(cyc);
      if (cap) begin
        if (!has || rdy_s) begin
          has = 1;
          exp_q.push_back(res);
          if (nruns < MAXN) nruns++;
        end else drop_q.push_back(cyc);
      end else if (has && rdy_s) has = 0;
    end
  end

  // Monitor: compare DUT outputs against the queued expectations.
  initial forever begin
    bit e;
    int got;
    @(negedge clk);
    if (rst_n) begin
      e = (err_q.size() > 0) && (err_q[0] == cyc);
      check("err_o", bus.err_o, e);
      if (e) void'(err_q.pop_front());
      e = (drop_q.size() > 0) && (drop_q[0] == cyc);
      check("drop_o", bus.drop_o, e);
      if (e) void'(drop_q.pop_front());
      check("valid_o", bus.valid_o, exp_q.size() != 0);
      check("nruns_o", bus.nruns_o, nruns);
      if (bus.valid_o && rdy_s && exp_q.size() > 0) begin
        got = int'(bus.len_o) | (bus.sat_o ? (1 << CNT_W) : 0);
        check("len_sat", got, exp_q.pop_front());
      end
    end
  end

  task automatic step(input logic rv, input logic fv);
    r_s = rv;
    f_s = fv;
    case (rdy_mode)
      0:       rdy_s = 1'($urandom_range(0, 1));
      1:       rdy_s = 1'b0;
      default: rdy_s = 1'b1;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic fv, input logic rv_end);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0);
    step(rv_end, fv);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    r_s = 1'b0; f_s = 1'b0;
    #1;
    check("rst_valid", bus.valid_o, 0);
    check("rst_len", bus.len_o, 0);
    check("rst_sat", bus.sat_o, 0);
    check("rst_drop", bus.drop_o, 0);
    check("rst_err", bus.err_o, 0);
    check("rst_nruns", bus.nruns_o, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int kind, len, gap;
    #1;
    do_reset();
    // basic
    rdy_mode = 2;
    run(5, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    // back-pressure and drop
    rdy_mode = 1;
    run(3, 1'b1, 1'b0); step(1'b0, 1'b0);
    run(7, 1'b1, 1'b0); step(1'b0, 1'b0);
    rdy_mode = 2;
    repeat (2) step(1'b0, 1'b0);
    // capture coinciding with consume
    rdy_mode = 1;
    run(4, 1'b1, 1'b0); step(1'b0, 1'b0);
    step(1'b1, 1'b0); step(1'b1, 1'b0);
    rdy_mode = 2;
    step(1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0);
    // saturation
    run(300, 1'b1, 1'b0); step(1'b0, 1'b0);
    run(254, 1'b1, 1'b0); step(1'b0, 1'b0);
    run(255, 1'b1, 1'b0); step(1'b0, 1'b0);
    // protocol errors
    step(1'b0, 1'b1); step(1'b0, 1'b0);
    run(3, 1'b0, 1'b0); step(1'b0, 1'b0);
    run(4, 1'b1, 1'b1); step(1'b0, 1'b0);
    // back-to-back with no idle gap
    run(2, 1'b1, 1'b0); run(3, 1'b1, 1'b0); step(1'b0, 1'b0);
    // reset mid-run
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
    do_reset();
    step(1'b0, 1'b1); step(1'b0, 1'b0);
    run(2, 1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0);
    // random traffic
    rdy_mode = 0;
    for (int k = 0; k < 250; k++) begin
      kind = $urandom_range(0, 9);
      len  = ($urandom_range(0, 19) == 0) ? $urandom_range(250, 300) : $urandom_range(1, 12);
      gap  = $urandom_range(0, 2);
      case (kind)
        0:       step(1'b0, 1'b1);
        1:       run(len, 1'b0, 1'b0);
        2:       run(len, 1'b1, 1'b1);
        default: run(len, 1'b1, 1'b0);
      endcase
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0);
    end
    rdy_mode = 2;
    repeat (5) step(1'b0, 1'b0);
    check("exp_q_empty", exp_q.size(), 0);
    check("err_q_empty", err_q.size(), 0);
    check("drop_q_empty", drop_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/run_len_meter.md
# run_len_meter

Downstream consumer of the `dff_onstate_1` run detector. It counts the clock cycles during which the detector's registered run flag `r` is high. On the detector's end-of-run pulse `f`, it captures that count into a single-entry result register. Results are offered to the next stage over a valid/ready handshake, with saturation, drop and protocol-error reporting.

## Interface
- CNT_W, 8, width of run-length counter and result
- NB_W, 16, width of the completed-runs counter
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- r  input  1  run-active flag from the upstream detector (registered there)
- f  input  1  end-of-run pulse from the upstream detector (one cycle)
- ready_i  input  1  downstream accepts the result when high with valid_o
- valid_o  output  1  result register holds an unconsumed result
- len_o  output  CNT_W  captured run length in cycles
- sat_o  output  1  captured run saturated (length ≥ 2^CNT_W−1)
- drop_o  output  1  one-cycle pulse: a completed run was discarded
- err_o  output  1  one-cycle pulse: protocol violation on r/f
- nruns_o  output  NB_W  number of runs captured into the result register, saturating

## Operation
- Counter FSM has two states:
  - IDLE: cnt held at 0.
  - COUNT: accumulates.
- IDLE transitions:
  - r=1, f=0 → COUNT, cnt=1, satf=0.
  - f=1 → err_o pulse, stay IDLE, nothing captured.
- COUNT transitions:
  - r=1, f=0 → cnt+1. At all-ones, cnt holds and satf is set.
  - f=1 → capture event with length cnt and sat satf, then → IDLE and cnt cleared.
  - r=0, f=0 → err_o pulse, → IDLE, cnt discarded (run ended without f).
- r=1 and f=1 together:
  - In COUNT: f wins. Capture occurs, err_o pulses, and r is ignored (cnt not incremented).
  - In IDLE: err_o pulses, no capture, stay IDLE.
- Output register is single-entry and independent of the counter. The counter never stalls.
- A capture event with valid_o=0, or with valid_o=1 and ready_i=1 (same cycle), loads len_o/sat_o. In both cases valid_o=1 next cycle, and nruns_o increments.
- A capture event with valid_o=1 and ready_i=0 keeps the old result. drop_o pulses, nruns_o is unchanged.
- With no capture event, valid_o=1 and ready_i=1 → valid_o=0 next cycle. len_o/sat_o hold their last values.
- nruns_o saturates at all-ones.
- len_o/sat_o are stable while valid_o=1 and ready_i=0.
- Reset values: valid_o=0, len_o=0, sat_o=0, drop_o=0, err_o=0, nruns_o=0, FSM=IDLE, cnt=0.
- Reset mid-run: the run is lost, and no f-related capture occurs after rst_n deasserts until a new r rising run.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- A run with r high for cycles t..t+N−1 and f high at t+N gives valid_o=1 with len_o=N at t+N+1.
- err_o and drop_o assert the cycle after the offending sample, for exactly one cycle.
- Back-to-back runs are supported:
  - r=1 in the cycle right after f starts a new count at 1.
  - Minimum upstream spacing is one idle cycle, but the spacing above must also work.
- Handshake: a transfer occurs on a clk edge with valid_o=1 and ready_i=1. ready_i may toggle freely. valid_o never drops without a transfer.
- Saturation:
  - cnt reaching 2^CNT_W−1 sets satf.
  - The captured len_o = 2^CNT_W−1 with sat_o=1.
  - A run of exactly 2^CNT_W−1 cycles also reports sat_o=1.

## Test plan
- Basic run: r high 5 cycles then f, ready_i=1 → valid_o one cycle later with len_o=5, sat_o=0, nruns_o=1, then valid_o=0.
- Back-pressure/drop: ready_i=0, runs of length 3 then 7 → len_o stays 3, drop_o pulses once at second f, nruns_o=1; on raising ready_i, valid_o falls next cycle.
- Simultaneous consume and capture: valid_o=1 (len 4), ready_i=1 in the same cycle f samples a length-2 run → no drop, len_o=2, valid_o stays 1, nruns_o=2.
- Saturation (CNT_W=8): r high 300 cycles then f → len_o=255, sat_o=1; r high 254 cycles → len_o=254, sat_o=0.
- Protocol errors:
  - f in IDLE → err_o pulse, no valid.
  - r drops without f after 3 cycles → err_o pulse, no capture.
  - r and f together during a run of 4 → len_o=4, err_o pulse.
- Reset mid-run: assert rst_n low after 6 cycles of r, release, send f only → all outputs 0, err_o pulses, no valid; a subsequent run of 2 plus f → len_o=2.
